// File: rtl/uart_lite_core_if.sv
// AXI4-Lite bus bundle for uart_lite_core; slave modport faces the core, master faces the requester.
interface uart_lite_core_if;
  logic [3:0]  axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [2:0]  axi_arprot;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [3:0]  axi_awaddr;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [2:0]  axi_awprot;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;

  modport slave (
    input  axi_araddr, axi_arvalid, axi_arprot, axi_rready,
    input  axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    output axi_arready, axi_rdata, axi_rresp, axi_rvalid,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid
  );

  modport master (
    output axi_araddr, axi_arvalid, axi_arprot, axi_rready,
    output axi_awaddr, axi_awvalid, axi_awprot, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    input  axi_arready, axi_rdata, axi_rresp, axi_rvalid,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid
  );
endinterface

// File: rtl/uart_lite_core.sv
// AXI4-Lite 8N1 UART with RX/TX FIFOs and a four-register map (RX, TX, STAT, CTRL).
// Define UART_LITE_INTR_EN to build the interrupt pulse logic; otherwise interrupt is tied low.
module uart_lite_core #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_lite_core_if.slave axi,
  input  logic            rxd,
  output logic            txd,
  output logic            interrupt
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // FIFO storage and pointers
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
  logic          rx_empty_c, rx_full_c, tx_empty_c, tx_full_c;
  logic [7:0]    rx_head_c, tx_head_c;

  assign rx_empty_c = (rx_wr_q == rx_rd_q);
  assign tx_empty_c = (tx_wr_q == tx_rd_q);
  assign rx_full_c  = (rx_wr_q[AW] != rx_rd_q[AW]) && (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]);
  assign tx_full_c  = (tx_wr_q[AW] != tx_rd_q[AW]) && (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]);
  assign rx_head_c  = rx_mem[rx_rd_q[AW-1:0]];
  assign tx_head_c  = tx_mem[tx_rd_q[AW-1:0]];

  logic overrun_q, frame_err_q, intr_en_q;
  logic rx_push_c, rx_pop_c, tx_push_c, tx_pop_c;
  logic overrun_set_c, frame_err_set_c;

  // Read channel
  logic        arready_q, rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        ar_acc_c, stat_rd_c;
  logic [1:0]  rd_sel_c;
  logic [31:0] stat_c;

  assign ar_acc_c  = axi.axi_arvalid & arready_q;
  assign rd_sel_c  = axi.axi_araddr[3:2];
  assign rx_pop_c  = ar_acc_c && (rd_sel_c == 2'd0) && !rx_empty_c;
  assign stat_rd_c = ar_acc_c && (rd_sel_c == 2'd2);
  assign stat_c    = {25'd0, frame_err_q, overrun_q, intr_en_q,
                      tx_full_c, tx_empty_c, rx_full_c, !rx_empty_c};

  always_comb begin
    rdata_d = 32'd0;
    rresp_d = RESP_OKAY;
    case (rd_sel_c)
      2'd0: begin
        if (rx_empty_c) rresp_d = RESP_SLVERR;
        else            rdata_d = {24'd0, rx_head_c};
      end
      2'd2:    rdata_d = stat_c;
      default: rdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
    end else if (ar_acc_c) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b1;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end else if (rvalid_q && axi.axi_rready) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
    end
  end

  // Write channel: aw and w are accepted together, one cycle after both are seen valid
  logic       awready_q, bvalid_q;
  logic [1:0] bresp_q;
  logic       wr_acc_c, tx_push_req_c, ctrl_wr_c, tx_flush_c, rx_flush_c;
  logic [1:0] wr_sel_c;

  assign wr_acc_c      = awready_q & axi.axi_awvalid & axi.axi_wvalid;
  assign wr_sel_c      = axi.axi_awaddr[3:2];
  assign tx_push_req_c = wr_acc_c && (wr_sel_c == 2'd1) && axi.axi_wstrb[0];
  assign ctrl_wr_c     = wr_acc_c && (wr_sel_c == 2'd3) && axi.axi_wstrb[0];
  assign tx_flush_c    = ctrl_wr_c & axi.axi_wdata[0];
  assign rx_flush_c    = ctrl_wr_c & axi.axi_wdata[1];
  assign tx_push_c     = tx_push_req_c && !tx_full_c && !tx_flush_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      awready_q <= !awready_q && !bvalid_q && axi.axi_awvalid && axi.axi_wvalid;
      if (wr_acc_c) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (tx_push_req_c && tx_full_c) ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && axi.axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign axi.axi_arready = arready_q;
  assign axi.axi_rvalid  = rvalid_q;
  assign axi.axi_rdata   = rdata_q;
  assign axi.axi_rresp   = rresp_q;
  assign axi.axi_awready = awready_q;
  assign axi.axi_wready  = awready_q;
  assign axi.axi_bvalid  = bvalid_q;
  assign axi.axi_bresp   = bresp_q;

  // Sticky error flags: a new error in the same cycle as a STAT read wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      intr_en_q   <= 1'b0;
    end else begin
      if (stat_rd_c)       overrun_q   <= 1'b0;
      if (overrun_set_c)   overrun_q   <= 1'b1;
      if (stat_rd_c)       frame_err_q <= 1'b0;
      if (frame_err_set_c) frame_err_q <= 1'b1;
      if (ctrl_wr_c)       intr_en_q   <= axi.axi_wdata[4];
    end
  end

  // FIFO pointers; a flush overrides any push or pop in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      tx_wr_q <= '0;
      tx_rd_q <= '0;
    end else begin
      if (rx_flush_c) begin
        rx_wr_q <= '0;
        rx_rd_q <= '0;
      end else begin
        if (rx_push_c) rx_wr_q <= rx_wr_q + PW'(1);
        if (rx_pop_c)  rx_rd_q <= rx_rd_q + PW'(1);
      end
      if (tx_flush_c) begin
        tx_wr_q <= '0;
        tx_rd_q <= '0;
      end else begin
        if (tx_push_c) tx_wr_q <= tx_wr_q + PW'(1);
        if (tx_pop_c)  tx_rd_q <= tx_rd_q + PW'(1);
      end
    end
  end

  logic [7:0] rx_shift_q, rx_shift_d;

  always_ff @(posedge clk) begin
    if (rx_push_c) rx_mem[rx_wr_q[AW-1:0]] <= rx_shift_q;
    if (tx_push_c) tx_mem[tx_wr_q[AW-1:0]] <= axi.axi_wdata[7:0];
  end

  // RX deserializer
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic          rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_meta_q  <= rxd;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  always_comb begin
    rx_state_d      = rx_state_q;
    rx_cnt_d        = rx_cnt_q + CW'(1);
    rx_bit_d        = rx_bit_q;
    rx_shift_d      = rx_shift_q;
    rx_push_c       = 1'b0;
    frame_err_set_c = 1'b0;
    overrun_set_c   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (!rx_sync_q)     frame_err_set_c = 1'b1;
          else if (rx_full_c) overrun_set_c   = 1'b1;
          else                rx_push_c       = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // TX serializer; a waiting byte is loaded straight out of the stop bit for back-to-back frames
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          txd_q, txd_d, tx_load_c;

  assign tx_load_c = !tx_empty_c && !tx_flush_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_pop_c   = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        txd_d    = 1'b1;
        if (tx_load_c) begin
          tx_pop_c   = 1'b1;
          tx_shift_d = tx_head_c;
          txd_d      = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          txd_d      = 1'b1;
          tx_state_d = TX_IDLE;
          if (tx_load_c) begin
            tx_pop_c   = 1'b1;
            tx_shift_d = tx_head_c;
            txd_d      = 1'b0;
            tx_state_d = TX_START;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign txd = txd_q;

`ifdef UART_LITE_INTR_EN
  // One-cycle pulse on RX becoming non-empty or TX draining empty
  logic rx_empty_prev_q, tx_empty_prev_q, intr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_empty_prev_q <= 1'b1;
      tx_empty_prev_q <= 1'b1;
      intr_q          <= 1'b0;
    end else begin
      rx_empty_prev_q <= rx_empty_c;
      tx_empty_prev_q <= tx_empty_c;
      intr_q          <= intr_en_q && ((rx_empty_prev_q && !rx_empty_c) ||
                                       (!tx_empty_prev_q && tx_empty_c));
    end
  end

  assign interrupt = intr_q;
`else
  assign interrupt = 1'b0;
`endif

  logic unused_c;
  assign unused_c = ^{axi.axi_arprot, axi.axi_awprot, axi.axi_araddr[1:0], axi.axi_awaddr[1:0],
                      axi.axi_wdata[31:8], axi.axi_wstrb[3:1]};
endmodule
